// File: rtl/hit_gen_pkg.sv
// Shared types and constants for the bowling hit generator: FSM state encoding,
// default parameter values and output field widths.
package hit_gen_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 1000000;
    localparam int PINS_PER_FRAME_DEF  = 10;
    localparam int NUM_FRAMES_DEF      = 3;

    localparam int PINS_W  = 4;
    localparam int FRAME_W = 2;

    typedef enum logic [1:0] {
        PLAY = 2'd0,
        FULL = 2'd1,
        OVER = 2'd2
    } state_e;

    // Counter width for a stable-cycle count; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hit_gen_debounce.sv
// Button conditioner: 2-flop synchronizer, stable-level counter and a registered
// single-cycle pulse on each debounced press (1->0). Releases produce no event.
module hit_gen_debounce
    import hit_gen_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_n_i,
    output logic press_o
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic             prev_q;
    logic             armed_q, armed_d;
    logic [1:0]       vld_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // A button already held at reset release must be seen genuinely released
    // (synchronizer output valid and debounced level high) before presses count.
    always_comb begin
        armed_d = armed_q | (vld_q[1] & stable_q & sync2_q);
        press_d = armed_q & prev_q & ~stable_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            prev_q   <= 1'b1;
            armed_q  <= 1'b0;
            vld_q    <= 2'b00;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync1_q  <= btn_n_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            prev_q   <= stable_q;
            armed_q  <= armed_d;
            vld_q    <= {vld_q[0], 1'b1};
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/hit_gen.sv
// Bowling hit generator: debounced hit/next buttons drive a PLAY/FULL/OVER
// frame FSM that emits one registered hit pulse per accepted pin.
module hit_gen
    import hit_gen_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int PINS_PER_FRAME  = PINS_PER_FRAME_DEF,
    parameter int NUM_FRAMES      = NUM_FRAMES_DEF
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               key_n,
    input  logic               next_n,
    output logic               hit,
    output logic [PINS_W-1:0]  pins,
    output logic [FRAME_W-1:0] frame,
    output logic               game_over
);

    localparam logic [1:0] ST_PLAY = PLAY;
    localparam logic [1:0] ST_FULL = FULL;
    localparam logic [1:0] ST_OVER = OVER;

    localparam logic [PINS_W-1:0]  PINS_MAX   = PINS_W'(PINS_PER_FRAME);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(NUM_FRAMES - 1);

    logic key_press, next_press;

    logic [1:0]         state_q, state_d;
    logic               hit_q, hit_d;
    logic [PINS_W-1:0]  pins_q, pins_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               over_q, over_d;

    hit_gen_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clk_i   (CLOCK_50),
        .rst_i   (reset),
        .btn_n_i (key_n),
        .press_o (key_press)
    );

    hit_gen_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_next_debounce (
        .clk_i   (CLOCK_50),
        .rst_i   (reset),
        .btn_n_i (next_n),
        .press_o (next_press)
    );

    always_comb begin
        state_d = state_q;
        hit_d   = 1'b0;
        pins_d  = pins_q;
        frame_d = frame_q;
        over_d  = over_q;

        // A coincident hit is credited to the current frame before the advance.
        if (state_q == ST_PLAY && key_press) begin
            hit_d  = 1'b1;
            pins_d = pins_q + 1'b1;
            if (pins_d == PINS_MAX) begin
                state_d = ST_FULL;
            end
        end

        if ((state_q == ST_PLAY || state_q == ST_FULL) && next_press) begin
            pins_d = '0;
            if (frame_q == FRAME_LAST) begin
                over_d  = 1'b1;
                state_d = ST_OVER;
            end else begin
                frame_d = frame_q + 1'b1;
                state_d = ST_PLAY;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= ST_PLAY;
            hit_q   <= 1'b0;
            pins_q  <= '0;
            frame_q <= '0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hit_q   <= hit_d;
            pins_q  <= pins_d;
            frame_q <= frame_d;
            over_q  <= over_d;
        end
    end

    assign hit       = hit_q;
    assign pins      = pins_q;
    assign frame     = frame_q;
    assign game_over = over_q;

endmodule

// File: tb/tb_hit_gen.sv
// Directed bench for hit_gen with a short debounce window: timing of the hit
// pulse, frame filling, frame advance, game over, coincident presses and reset.
module tb_hit_gen;
    import hit_gen_pkg::*;

    logic       CLOCK_50;
    logic       reset;
    logic       key_n;
    logic       next_n;
    logic       hit;
    logic [3:0] pins;
    logic [1:0] frame;
    logic       game_over;

    int checks   = 0;
    int failures = 0;
    int hit_cnt  = 0;
    int base;

    hit_gen #(
        .DEBOUNCE_CYCLES (4),
        .PINS_PER_FRAME  (10),
        .NUM_FRAMES      (3)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .key_n     (key_n),
        .next_n    (next_n),
        .hit       (hit),
        .pins      (pins),
        .frame     (frame),
        .game_over (game_over)
    );

    // clock / reset
    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    // hit pulse monitor, sampled mid-cycle
    always @(negedge CLOCK_50) begin
        if (hit === 1'b1) hit_cnt = hit_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    task automatic do_reset();
        tick(1);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(5);
    endtask

    task automatic press_key();
        key_n = 1'b0;
        tick(8);
        key_n = 1'b1;
        tick(8);
    endtask

    task automatic press_next();
        next_n = 1'b0;
        tick(8);
        next_n = 1'b1;
        tick(8);
    endtask

    task automatic press_both();
        key_n  = 1'b0;
        next_n = 1'b0;
        tick(8);
        key_n  = 1'b1;
        next_n = 1'b1;
        tick(8);
    endtask

    initial begin
        reset  = 1'b1;
        key_n  = 1'b1;
        next_n = 1'b1;
        tick(3);
        check("rst_hit",       32'(hit),       32'd0);
        check("rst_pins",      32'(pins),      32'd0);
        check("rst_frame",     32'(frame),     32'd0);
        check("rst_game_over", 32'(game_over), 32'd0);
        check("rst_state",     32'(dut.state_q), 32'(PLAY));
        reset = 1'b0;
        tick(5);

        // glitch shorter than the debounce window
        base  = hit_cnt;
        key_n = 1'b0;
        tick(3);
        key_n = 1'b1;
        tick(12);
        check("short_hits", 32'(hit_cnt - base), 32'd0);
        check("short_pins", 32'(pins), 32'd0);

        // first press: pulse exactly 7 edges after the first low sample
        base  = hit_cnt;
        key_n = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check($sformatf("lat_hit_%0d", i), 32'(hit), (i == 7) ? 32'd1 : 32'd0);
        end
        key_n = 1'b1;
        tick(10);
        check("lat_hits", 32'(hit_cnt - base), 32'd1);
        check("lat_pins", 32'(pins), 32'd1);

        // fill frame 0 with 12 presses
        do_reset();
        base = hit_cnt;
        for (int i = 0; i < 12; i++) press_key();
        check("full_hits",  32'(hit_cnt - base), 32'd10);
        check("full_pins",  32'(pins), 32'd10);
        check("full_state", 32'(dut.state_q), 32'(FULL));
        check("full_frame", 32'(frame), 32'd0);

        // advance through the frames to game over
        press_next();
        check("adv1_frame", 32'(frame), 32'd1);
        check("adv1_pins",  32'(pins),  32'd0);
        press_next();
        check("adv2_frame", 32'(frame), 32'd2);
        check("adv2_over",  32'(game_over), 32'd0);
        press_next();
        check("adv3_frame", 32'(frame), 32'd2);
        check("adv3_over",  32'(game_over), 32'd1);
        check("adv3_state", 32'(dut.state_q), 32'(OVER));
        base = hit_cnt;
        press_key();
        press_key();
        press_next();
        check("over_hits",  32'(hit_cnt - base), 32'd0);
        check("over_pins",  32'(pins),  32'd0);
        check("over_frame", 32'(frame), 32'd2);

        // coincident key and next in PLAY with 3 pins
        do_reset();
        for (int i = 0; i < 3; i++) press_key();
        check("co_pre_pins", 32'(pins), 32'd3);
        base = hit_cnt;
        press_both();
        check("co_hits",  32'(hit_cnt - base), 32'd1);
        check("co_pins",  32'(pins),  32'd0);
        check("co_frame", 32'(frame), 32'd1);

        // coincident key and next in FULL: no hit, advance applies
        for (int i = 0; i < 10; i++) press_key();
        check("cofull_state", 32'(dut.state_q), 32'(FULL));
        base = hit_cnt;
        press_both();
        check("cofull_hits",  32'(hit_cnt - base), 32'd0);
        check("cofull_frame", 32'(frame), 32'd2);
        check("cofull_pins",  32'(pins),  32'd0);

        // asynchronous reset clears outputs without a clock edge
        #3;
        reset = 1'b1;
        #2;
        check("async_frame", 32'(frame), 32'd0);
        check("async_state", 32'(dut.state_q), 32'(PLAY));
        tick(2);
        reset = 1'b0;
        tick(5);

        // reset mid-debounce with the key held through release
        base  = hit_cnt;
        key_n = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(20);
        check("held_hits",      32'(hit_cnt - base), 32'd0);
        check("held_pins",      32'(pins),      32'd0);
        check("held_frame",     32'(frame),     32'd0);
        check("held_game_over", 32'(game_over), 32'd0);
        key_n = 1'b1;
        tick(10);
        check("held_rel_hits", 32'(hit_cnt - base), 32'd0);
        press_key();
        check("held_new_hits", 32'(hit_cnt - base), 32'd1);
        check("held_new_pins", 32'(pins), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
